t02_writeback_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: ALU results and memory load data.
- Each source uses a valid/ready handshake; a round-robin arbiter grants one per cycle.
- The winner drives a registered write command (reg_write/write_index/write_data) into t02_register_file.
- A pending-destination scoreboard flags in-flight destinations so the decode stage can stall on read-after-write hazards.

---
 rtl/t02_writeback_arbiter_pkg.sv | 19 +
 rtl/t02_writeback_arbiter_if.sv | 28 ++
 rtl/t02_writeback_arbiter_scoreboard.sv | 40 ++++
 rtl/t02_writeback_arbiter.sv | 93 +++++++++
 tb/tb_t02_writeback_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/t02_writeback_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter slice: source enum,
// registered write-command struct, and default widths.
package t02_wb_pkg;

   localparam int IDX_W  = 5;
   localparam int DATA_W = 32;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_t;

   typedef struct packed {
      logic              valid;
      logic [IDX_W-1:0]  index;
      logic [DATA_W-1:0] data;
   } wb_cmd_t;

endpackage

// File: rtl/t02_writeback_arbiter_if.sv
// Writeback request bundle: ALU and load sources, each a valid/ready handshake.
// master = requesters, slave = arbiter.
interface t02_wb_if #(
   parameter int IDX_W  = t02_wb_pkg::IDX_W,
   parameter int DATA_W = t02_wb_pkg::DATA_W
);
   logic              alu_valid;
   logic [IDX_W-1:0]  alu_index;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              mem_valid;
   logic [IDX_W-1:0]  mem_index;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   modport master (
      output alu_valid, alu_index, alu_data,
      output mem_valid, mem_index, mem_data,
      input  alu_ready, mem_ready
   );

   modport slave (
      input  alu_valid, alu_index, alu_data,
      input  mem_valid, mem_index, mem_data,
      output alu_ready, mem_ready
   );
endinterface

// File: rtl/t02_writeback_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set on issue, cleared on
// commit; register 0 never becomes pending.
module t02_wb_scoreboard #(
   parameter int IDX_W = t02_wb_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] rd_idx1,
   input  logic [IDX_W-1:0] rd_idx2,
   output logic             busy1,
   output logic             busy2
);

   localparam int NREG = 1 << IDX_W;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
   end

   // Set is applied after clear so a newer producer on the same index wins.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) pending <= '0;
      else       pending <= (pending & ~clr_mask) | set_mask;
   end

   assign busy1 = (rd_idx1 != '0) && pending[rd_idx1];
   assign busy2 = (rd_idx2 != '0) && pending[rd_idx2];

endmodule

// File: rtl/t02_writeback_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port, with a
// pending-destination scoreboard. Optional bypass: define T02_WB_FORWARD_EN.
import t02_wb_pkg::*;

module t02_writeback_arbiter #(
   parameter int DATA_W = t02_wb_pkg::DATA_W,
   parameter int IDX_W  = t02_wb_pkg::IDX_W
) (
   input  logic              clk,
   input  logic              nRST,
   t02_wb_if.slave           wb,
   input  logic              issue_valid,
   input  logic [IDX_W-1:0]  issue_index,
   input  logic [IDX_W-1:0]  read_index1,
   input  logic [IDX_W-1:0]  read_index2,
   output logic              busy1,
   output logic              busy2,
`ifdef T02_WB_FORWARD_EN
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
   output logic              fwd_sel1,
   output logic              fwd_sel2,
`endif
   output logic              reg_write,
   output logic [IDX_W-1:0]  write_index,
   output logic [DATA_W-1:0] write_data
);

   wb_src_t last_grant;
   wb_cmd_t cmd;
   logic    grant_alu;
   logic    grant_mem;
   logic    sb_busy1;
   logic    sb_busy2;

   // MEM wins alone, or on a tie when ALU had the last grant. Gated by reset so
   // nothing is accepted while the block is held in reset.
   assign grant_mem = nRST && wb.mem_valid && (!wb.alu_valid || (last_grant == SRC_ALU));
   assign grant_alu = nRST && wb.alu_valid && !grant_mem;

   assign wb.mem_ready = grant_mem;
   assign wb.alu_ready = grant_alu;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cmd        <= '0;
         last_grant <= SRC_ALU;
      end else if (grant_mem) begin
         cmd.valid  <= (wb.mem_index != '0);
         cmd.index  <= wb.mem_index;
         cmd.data   <= wb.mem_data;
         last_grant <= SRC_MEM;
      end else if (grant_alu) begin
         cmd.valid  <= (wb.alu_index != '0);
         cmd.index  <= wb.alu_index;
         cmd.data   <= wb.alu_data;
         last_grant <= SRC_ALU;
      end else begin
         cmd.valid  <= 1'b0;
      end
   end

   assign reg_write   = cmd.valid;
   assign write_index = cmd.index;
   assign write_data  = cmd.data;

   t02_wb_scoreboard #(.IDX_W(IDX_W)) u_scoreboard (
      .clk     (clk),
      .nRST    (nRST),
      .set_en  (issue_valid),
      .set_idx (issue_index),
      .clr_en  (cmd.valid),
      .clr_idx (cmd.index),
      .rd_idx1 (read_index1),
      .rd_idx2 (read_index2),
      .busy1   (sb_busy1),
      .busy2   (sb_busy2)
   );

`ifdef T02_WB_FORWARD_EN
   // A committing write satisfies the reader this cycle via the bypass path.
   assign fwd_sel1  = cmd.valid && (cmd.index == read_index1);
   assign fwd_sel2  = cmd.valid && (cmd.index == read_index2);
   assign fwd_data1 = cmd.data;
   assign fwd_data2 = cmd.data;
   assign busy1     = sb_busy1 && !fwd_sel1;
   assign busy2     = sb_busy2 && !fwd_sel2;
`else
   assign busy1     = sb_busy1;
   assign busy2     = sb_busy2;
`endif

endmodule

// File: tb/tb_t02_writeback_arbiter.sv
// Directed self-checking bench for t02_writeback_arbiter (default and
// T02_WB_FORWARD_EN builds).
module tb_t02_writeback_arbiter;
   import t02_wb_pkg::*;

   logic              clk = 1'b0;
   logic              nRST;
   logic              issue_valid;
   logic [IDX_W-1:0]  issue_index;
   logic [IDX_W-1:0]  read_index1;
   logic [IDX_W-1:0]  read_index2;
   logic              busy1;
   logic              busy2;
   logic              reg_write;
   logic [IDX_W-1:0]  write_index;
   logic [DATA_W-1:0] write_data;
`ifdef T02_WB_FORWARD_EN
   logic [DATA_W-1:0] fwd_data1;
   logic [DATA_W-1:0] fwd_data2;
   logic              fwd_sel1;
   logic              fwd_sel2;
`endif

   int n_cmp = 0;
   int n_err = 0;

   t02_wb_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) wb ();

   t02_writeback_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .nRST        (nRST),
      .wb          (wb),
      .issue_valid (issue_valid),
      .issue_index (issue_index),
      .read_index1 (read_index1),
      .read_index2 (read_index2),
      .busy1       (busy1),
      .busy2       (busy2),
`ifdef T02_WB_FORWARD_EN
      .fwd_data1   (fwd_data1),
      .fwd_data2   (fwd_data2),
      .fwd_sel1    (fwd_sel1),
      .fwd_sel2    (fwd_sel2),
`endif
      .reg_write   (reg_write),
      .write_index (write_index),
      .write_data  (write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nRST          = 1'b0;
      wb.alu_valid  = 1'b0;
      wb.alu_index  = '0;
      wb.alu_data   = '0;
      wb.mem_valid  = 1'b0;
      wb.mem_index  = '0;
      wb.mem_data   = '0;
      issue_valid   = 1'b0;
      issue_index   = '0;
      read_index1   = '0;
      read_index2   = '0;
      #12 nRST = 1'b1;
      step();

      // Reset state
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_write_index", {27'd0, write_index}, 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
      chk("rst_mem_ready", {31'd0, wb.mem_ready}, 32'd0);

      // First tie after reset goes to MEM, then ALU
      wb.alu_valid = 1'b1; wb.alu_index = 5'd3; wb.alu_data = 32'h11;
      wb.mem_valid = 1'b1; wb.mem_index = 5'd4; wb.mem_data = 32'h22;
      #1;
      chk("tie1_mem_ready", {31'd0, wb.mem_ready}, 32'd1);
      chk("tie1_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
      step();
      chk("tie1_reg_write", {31'd0, reg_write}, 32'd1);
      chk("tie1_write_index", {27'd0, write_index}, 32'd4);
      chk("tie1_write_data", write_data, 32'h22);
      wb.mem_valid = 1'b0;
      #1;
      chk("c2_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
      step();
      chk("c3_write_index", {27'd0, write_index}, 32'd3);
      chk("c3_write_data", write_data, 32'h11);
      wb.alu_valid = 1'b0;
      #1;
      chk("idle_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
      chk("idle_mem_ready", {31'd0, wb.mem_ready}, 32'd0);
      step();
      chk("idle_reg_write", {31'd0, reg_write}, 32'd0);

      // Continuous contention from a fresh reset: MEM, ALU, MEM, ...
      nRST = 1'b0; #2 nRST = 1'b1;
      wb.alu_valid = 1'b1; wb.alu_index = 5'd5; wb.alu_data = 32'hA5;
      wb.mem_valid = 1'b1; wb.mem_index = 5'd6; wb.mem_data = 32'hB6;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_mem_ready", {31'd0, wb.mem_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_alu_ready", {31'd0, wb.alu_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
         step();
         chk("rr_write_index", {27'd0, write_index}, (k % 2 == 0) ? 32'd6 : 32'd5);
      end

      // Index 0: accepted, never written, never pending
      wb.mem_valid = 1'b0;
      wb.alu_index = 5'd0; wb.alu_data = 32'hDEAD;
      issue_valid = 1'b1; issue_index = 5'd0; read_index1 = 5'd0;
      #1;
      chk("idx0_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
      step();
      wb.alu_valid = 1'b0; issue_valid = 1'b0;
      #1;
      chk("idx0_reg_write", {31'd0, reg_write}, 32'd0);
      chk("idx0_busy1", {31'd0, busy1}, 32'd0);

      // Issue to 7, busy until the writeback commits
      issue_valid = 1'b1; issue_index = 5'd7;
      step();
      issue_valid = 1'b0; read_index1 = 5'd7;
      #1;
      chk("i7_busy1_a", {31'd0, busy1}, 32'd1);
      step();
      chk("i7_busy1_b", {31'd0, busy1}, 32'd1);
      wb.alu_valid = 1'b1; wb.alu_index = 5'd7; wb.alu_data = 32'h77;
      #1;
      chk("i7_alu_ready", {31'd0, wb.alu_ready}, 32'd1);
      step();
      wb.alu_valid = 1'b0;
      #1;
      chk("i7_commit_reg_write", {31'd0, reg_write}, 32'd1);
      chk("i7_commit_write_index", {27'd0, write_index}, 32'd7);
`ifdef T02_WB_FORWARD_EN
      chk("i7_commit_busy1", {31'd0, busy1}, 32'd0);
      chk("i7_fwd_sel1", {31'd0, fwd_sel1}, 32'd1);
      chk("i7_fwd_data1", fwd_data1, 32'h77);
`else
      chk("i7_commit_busy1", {31'd0, busy1}, 32'd1);
`endif
      step();
      chk("i7_after_busy1", {31'd0, busy1}, 32'd0);
      chk("i7_after_reg_write", {31'd0, reg_write}, 32'd0);

      // Issue to 9 coincides with a commit to 9: the bit survives
      issue_valid = 1'b1; issue_index = 5'd9; read_index2 = 5'd9;
      wb.alu_valid = 1'b1; wb.alu_index = 5'd9; wb.alu_data = 32'h99;
      step();
      wb.alu_valid = 1'b0;
      #1;
      chk("i9_commit_reg_write", {31'd0, reg_write}, 32'd1);
      step();
      issue_valid = 1'b0;
      #1;
      chk("i9_busy2", {31'd0, busy2}, 32'd1);
      chk("i9_reg_write_idle", {31'd0, reg_write}, 32'd0);

      // Reset mid-operation with a held request and a pending bit
      wb.mem_valid = 1'b1; wb.mem_index = 5'd12; wb.mem_data = 32'hC;
      step();
      #1;
      nRST = 1'b0;
      #1;
      chk("mrst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("mrst_write_index", {27'd0, write_index}, 32'd0);
      chk("mrst_write_data", write_data, 32'd0);
      chk("mrst_busy2", {31'd0, busy2}, 32'd0);
      chk("mrst_mem_ready", {31'd0, wb.mem_ready}, 32'd0);
      #2 nRST = 1'b1;
      wb.alu_valid = 1'b1; wb.alu_index = 5'd3; wb.alu_data = 32'h33;
      #1;
      chk("prst_tie_mem_ready", {31'd0, wb.mem_ready}, 32'd1);
      chk("prst_tie_alu_ready", {31'd0, wb.alu_ready}, 32'd0);
      chk("prst_busy2", {31'd0, busy2}, 32'd0);
      step();
      chk("prst_write_index", {27'd0, write_index}, 32'd12);
      wb.alu_valid = 1'b0; wb.mem_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
